// File: rtl/pyfive_pad_mux.sv
// ---------------------------------------------------------------------------
// pyfive_pad_mux
//
// Register-programmable pad multiplexer for the user-area wrapper. Each pad
// picks one of four sources: a tie-off, the user core, a software-driven
// output bit, or a software-readable input. The block also provides
// synchronised pad input readback, rising-edge capture with per-pad
// interrupt enables, and a Wishbone classic slave for configuration.
//
// Parameters:
//   N_PADS    number of pads handled (1..64)
//   CORE_LO   lowest pad index wired to the core window
//   CORE_W    core window width (CORE_LO + CORE_W <= N_PADS)
//   BASE_ADDR Wishbone base address of the 64-byte register window
//
// Ports:
//   wb_clk_i, wb_rst_i         clock and synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i       Wishbone classic controls
//   wbs_sel_i                  byte enables
//   wbs_adr_i, wbs_dat_i       address and write data
//   wbs_ack_o, wbs_dat_o       acknowledge and registered read data
//   core_out, core_oeb         core-side pad drive / output-enable-bar
//   core_in                    pad inputs of the core window (combinational)
//   io_in                      pad inputs
//   io_out, io_oeb             pad drive / output-enable-bar
//   irq                        registered interrupt (any enabled EDGE bit)
// ---------------------------------------------------------------------------
module pyfive_pad_mux #(
  parameter int          N_PADS    = 38,
  parameter int          CORE_LO   = 11,
  parameter int          CORE_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [CORE_W-1:0] core_out,
  input  logic [CORE_W-1:0] core_oeb,
  output logic [CORE_W-1:0] core_in,
  input  logic [N_PADS-1:0] io_in,
  output logic [N_PADS-1:0] io_out,
  output logic [N_PADS-1:0] io_oeb,
  output logic              irq
);

  // Pad modes
  localparam logic [1:0] MODE_TIE   = 2'd0;
  localparam logic [1:0] MODE_CORE  = 2'd1;
  localparam logic [1:0] MODE_SWOUT = 2'd2;
  localparam logic [1:0] MODE_SWIN  = 2'd3;

  // One bit per implemented pad; bits at or above N_PADS stay 0 forever.
  function automatic logic [63:0] padMask();
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (i < N_PADS);
    return m;
  endfunction

  // Two mode bits per implemented pad.
  function automatic logic [127:0] modeMask();
    logic [127:0] m;
    for (int i = 0; i < 64; i++) m[2*i +: 2] = (i < N_PADS) ? 2'b11 : 2'b00;
    return m;
  endfunction

  // Pads inside the core window come out of reset connected to the core.
  function automatic logic [127:0] modeReset();
    logic [127:0] m;
    for (int i = 0; i < 64; i++)
      m[2*i +: 2] = (i >= CORE_LO && i < CORE_LO + CORE_W && i < N_PADS) ? MODE_CORE : MODE_TIE;
    return m;
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [31:0] mask);
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  localparam logic [63:0]  PAD_MASK   = padMask();
  localparam logic [127:0] MODE_MASK  = modeMask();
  localparam logic [127:0] MODE_RESET = modeReset();

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } wbState_t;

  wbState_t       r_state;
  wbState_t       w_stateNext;

  logic [127:0]   r_mode;
  logic [63:0]    r_out;
  logic [63:0]    r_edge;
  logic [63:0]    r_irqEn;
  logic [63:0]    r_sync1;
  logic [63:0]    r_sync2;
  logic [31:0]    r_datO;
  logic           r_irq;

  logic [63:0]    w_padIn;
  logic           w_hit;
  logic           w_access;
  logic           w_write;
  logic [3:0]     w_wordIdx;
  logic [31:0]    w_byteMask;
  logic [31:0]    w_readData;
  logic [63:0]    w_rise;
  logic [63:0]    w_edgeClr;
  logic           w_unused;

  assign w_unused   = ^wbs_adr_i[1:0];

  assign w_hit      = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  // A new access is only taken from IDLE, so a held stb acks every other cycle.
  assign w_access   = wbs_cyc_i & wbs_stb_i & w_hit & (r_state == ST_IDLE);
  assign w_write    = w_access & wbs_we_i;
  assign w_wordIdx  = wbs_adr_i[5:2];
  assign w_byteMask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  always_comb begin
    w_padIn             = '0;
    w_padIn[N_PADS-1:0] = io_in;
  end

  // The sync pipeline's second stage is the architectural input value;
  // a rise is seen when the first stage has just gone high.
  assign w_rise = r_sync1 & ~r_sync2;

  always_comb begin
    w_edgeClr = '0;
    if (w_write && w_wordIdx == 4'd8)
      w_edgeClr[31:0] = wbs_dat_i & w_byteMask;
    if (w_write && w_wordIdx == 4'd9)
      w_edgeClr[63:32] = wbs_dat_i & w_byteMask;
  end

  always_comb begin
    w_readData = '0;
    case (w_wordIdx)
      4'd0:    w_readData = r_mode[31:0];
      4'd1:    w_readData = r_mode[63:32];
      4'd2:    w_readData = r_mode[95:64];
      4'd3:    w_readData = r_mode[127:96];
      4'd4:    w_readData = r_out[31:0];
      4'd5:    w_readData = r_out[63:32];
      4'd6:    w_readData = r_sync2[31:0];
      4'd7:    w_readData = r_sync2[63:32];
      4'd8:    w_readData = r_edge[31:0];
      4'd9:    w_readData = r_edge[63:32];
      4'd10:   w_readData = r_irqEn[31:0];
      4'd11:   w_readData = r_irqEn[63:32];
      default: w_readData = '0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_stateNext = ST_ACK;
      ST_ACK:  w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_stateNext;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mode  <= MODE_RESET;
      r_out   <= '0;
      r_edge  <= '0;
      r_irqEn <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_datO  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= w_padIn;
      r_sync2 <= r_sync1;
      // Clear first, then OR in new rises so a simultaneous set wins.
      r_edge  <= ((r_edge & ~w_edgeClr) | w_rise) & PAD_MASK;
      r_irq   <= |(r_edge & r_irqEn);
      // Read data is only meaningful during the ack cycle; zero otherwise.
      r_datO  <= w_access ? w_readData : '0;
      if (w_write) begin
        case (w_wordIdx)
          4'd0:  r_mode[31:0]    <= mergeWord(r_mode[31:0],    wbs_dat_i, w_byteMask) & MODE_MASK[31:0];
          4'd1:  r_mode[63:32]   <= mergeWord(r_mode[63:32],   wbs_dat_i, w_byteMask) & MODE_MASK[63:32];
          4'd2:  r_mode[95:64]   <= mergeWord(r_mode[95:64],   wbs_dat_i, w_byteMask) & MODE_MASK[95:64];
          4'd3:  r_mode[127:96]  <= mergeWord(r_mode[127:96],  wbs_dat_i, w_byteMask) & MODE_MASK[127:96];
          4'd4:  r_out[31:0]     <= mergeWord(r_out[31:0],     wbs_dat_i, w_byteMask) & PAD_MASK[31:0];
          4'd5:  r_out[63:32]    <= mergeWord(r_out[63:32],    wbs_dat_i, w_byteMask) & PAD_MASK[63:32];
          4'd10: r_irqEn[31:0]   <= mergeWord(r_irqEn[31:0],   wbs_dat_i, w_byteMask) & PAD_MASK[31:0];
          4'd11: r_irqEn[63:32]  <= mergeWord(r_irqEn[63:32],  wbs_dat_i, w_byteMask) & PAD_MASK[63:32];
          default: ;
        endcase
      end
    end
  end

  // Pad mux. Outside the core window there is no core signal to route,
  // so mode CORE collapses to the tie-off there.
  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    logic [1:0] w_mode;
    assign w_mode = r_mode[2*p +: 2];
    if (p >= CORE_LO && p < CORE_LO + CORE_W) begin : g_core
      assign io_out[p] = (w_mode == MODE_CORE)  ? core_out[p-CORE_LO] :
                         (w_mode == MODE_SWOUT) ? r_out[p] :
                         (w_mode == MODE_SWIN)  ? 1'b0 : 1'b1;
      assign io_oeb[p] = (w_mode == MODE_CORE)  ? core_oeb[p-CORE_LO] :
                         (w_mode == MODE_SWOUT) ? 1'b0 : 1'b1;
    end else begin : g_fixed
      assign io_out[p] = (w_mode == MODE_SWOUT) ? r_out[p] :
                         (w_mode == MODE_SWIN)  ? 1'b0 : 1'b1;
      assign io_oeb[p] = (w_mode == MODE_SWOUT) ? 1'b0 : 1'b1;
    end
  end

  assign core_in   = io_in[CORE_LO +: CORE_W];
  assign wbs_ack_o = (r_state == ST_ACK);
  assign wbs_dat_o = r_datO;
  assign irq       = r_irq;

endmodule

// File: tb/tb_pyfive_pad_mux.sv
// ---------------------------------------------------------------------------
// tb_pyfive_pad_mux
//
// Self-checking bench for pyfive_pad_mux. A per-pad behavioural model
// (arrays of modes, output bits, edge flags, enables and a two-deep input
// history) tracks what the block must present; a negedge process compares
// every output against it each cycle. Directed stimulus adds literal,
// hand-computed expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_pyfive_pad_mux;

  localparam int          N    = 38;
  localparam int          LO   = 11;
  localparam int          W    = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0;
  logic          wbs_stb_i = 1'b0;
  logic          wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = 32'h0;
  logic [31:0]   wbs_dat_i = 32'h0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [W-1:0]  core_out = 16'hA5A5;
  logic [W-1:0]  core_oeb = 16'h0000;
  logic [W-1:0]  core_in;
  logic [N-1:0]  io_in = '0;
  logic [N-1:0]  io_out;
  logic [N-1:0]  io_oeb;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

  pyfive_pad_mux #(
    .N_PADS(N), .CORE_LO(LO), .CORE_W(W), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Model state: one entry per pad.
  int          mMode[64];
  bit          mOut[64];
  bit          mEdge[64];
  bit          mIrqen[64];
  bit          mS1[64];
  bit          mS2[64];
  bit          mAck;
  logic [31:0] mDat;
  bit          mIrq;

  bit          mAcc;
  bit          mIrqNext;
  bit          mRise[64];
  logic [31:0] mRd;
  int          mIdx;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int idx);
    logic [31:0] r;
    int pad;
    r = '0;
    if (idx <= 3) begin
      for (int k = 0; k < 16; k++) begin
        pad = idx * 16 + k;
        if (pad < N) r[2*k +: 2] = 2'(mMode[pad]);
      end
    end else if (idx <= 11) begin
      for (int i = 0; i < 32; i++) begin
        pad = (idx % 2) * 32 + i;
        if (pad < N) begin
          if (idx == 4 || idx == 5)  r[i] = mOut[pad];
          if (idx == 6 || idx == 7)  r[i] = mS2[pad];
          if (idx == 8 || idx == 9)  r[i] = mEdge[pad];
          if (idx == 10 || idx == 11) r[i] = mIrqen[pad];
        end
      end
    end
    return r;
  endfunction

  task automatic modelWrite(input int idx, input logic [3:0] sel, input logic [31:0] dat);
    int pad;
    for (int i = 0; i < 32; i++) begin
      if (sel[i/8]) begin
        if (idx <= 3) begin
          pad = idx * 16 + i / 2;
          if (pad < N) begin
            if (dat[i]) mMode[pad] = mMode[pad] | (1 << (i % 2));
            else        mMode[pad] = mMode[pad] & ~(1 << (i % 2));
          end
        end else if (idx <= 11) begin
          pad = (idx % 2) * 32 + i;
          if (pad < N) begin
            if (idx == 4 || idx == 5)   mOut[pad] = dat[i];
            if ((idx == 8 || idx == 9) && dat[i]) mEdge[pad] = 1'b0;
            if (idx == 10 || idx == 11) mIrqen[pad] = dat[i];
          end
        end
      end
    end
  endtask

  // Model update on each rising edge, using pre-edge state throughout.
  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int p = 0; p < 64; p++) begin
        mMode[p]  = (p >= LO && p < LO + W) ? 1 : 0;
        mOut[p]   = 0; mEdge[p] = 0; mIrqen[p] = 0; mS1[p] = 0; mS2[p] = 0;
      end
      mAck = 0; mDat = '0; mIrq = 0;
    end else begin
      mAcc = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i >> 6) == (BASE >> 6)) && !mAck;
      mIdx = int'((wbs_adr_i % 64) / 4);
      mRd  = mAcc ? modelRead(mIdx) : 32'h0;
      mIrqNext = 0;
      for (int p = 0; p < N; p++) begin
        mIrqNext = mIrqNext | (mEdge[p] & mIrqen[p]);
        mRise[p] = mS1[p] && !mS2[p];
      end
      if (mAcc && wbs_we_i) modelWrite(mIdx, wbs_sel_i, wbs_dat_i);
      for (int p = 0; p < N; p++) begin
        if (mRise[p]) mEdge[p] = 1;
        mS2[p] = mS1[p];
        mS1[p] = io_in[p];
      end
      mAck = mAcc; mDat = mRd; mIrq = mIrqNext;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge wb_clk_i) begin
    logic [N-1:0] eOut;
    logic [N-1:0] eOeb;
    int m;
    if (cmpOn) begin
      for (int p = 0; p < N; p++) begin
        m = mMode[p];
        if (m == 1 && !(p >= LO && p < LO + W)) m = 0;
        case (m)
          0:       begin eOut[p] = 1'b1;           eOeb[p] = 1'b1; end
          1:       begin eOut[p] = core_out[p-LO]; eOeb[p] = core_oeb[p-LO]; end
          2:       begin eOut[p] = mOut[p];        eOeb[p] = 1'b0; end
          default: begin eOut[p] = 1'b0;           eOeb[p] = 1'b1; end
        endcase
      end
      checkOutput("ack", wbs_ack_o, mAck);
      checkOutput("dat_o", wbs_dat_o, mDat);
      checkOutput("irq", irq, mIrq);
      checkOutput("io_out", io_out, eOut);
      checkOutput("io_oeb", io_oeb, eOeb);
      checkOutput("core_in", core_in, io_in[LO +: W]);
    end
  end

  // One Wishbone access; inputs change 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                               input logic [31:0] dat, output logic [31:0] rdat);
    int  n;
    bit  got;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    got = 0; n = 0;
    while (!got && n < 8) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (wbs_ack_o) got = 1;
    end
    rdat = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checkOutput("ack_latency", n, 1);
    @(posedge wb_clk_i); #1;
    checkOutput("ack_width", wbs_ack_o, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int acks;

    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    cmpOn    = 1'b1;

    // Reset state of the pads
    checkOutput("rst_oeb", io_oeb, {11'h7FF, 16'h0000, 11'h7FF});
    checkOutput("rst_out", io_out, {11'h7FF, 16'hA5A5, 11'h7FF});
    checkOutput("rst_irq", irq, 1'b0);

    applyStimulus(BASE + 32'h00, 0, 4'hF, 32'h0, rd);
    checkOutput("mode0_rst", rd, 32'h5540_0000);

    // Software output on pads 0..15
    applyStimulus(BASE + 32'h10, 1, 4'hF, 32'hFFFF_FFFF, rd);
    applyStimulus(BASE + 32'h00, 1, 4'hF, 32'hAAAA_AAAA, rd);
    checkOutput("swout_out", io_out[15:0], 16'hFFFF);
    checkOutput("swout_oeb", io_oeb[15:0], 16'h0000);

    // Byte-lane write of MODE1: only pads 20..23 become SWIN
    applyStimulus(BASE + 32'h04, 1, 4'b0010, 32'hFFFF_FFFF, rd);
    applyStimulus(BASE + 32'h04, 0, 4'hF, 32'h0, rd);
    checkOutput("mode1_partial", rd, 32'h0015_FF55);
    checkOutput("swin_oeb", io_oeb[23:20], 4'hF);
    checkOutput("swin_out", io_out[23:20], 4'h0);

    // Core paths are combinational
    core_out = 16'h5A3C; core_oeb = 16'hC30F;
    @(posedge wb_clk_i); #1;
    checkOutput("core_out_26_24", io_out[26:24], 3'b010);
    checkOutput("core_oeb_26_24", io_oeb[26:24], 3'b110);

    // Unimplemented OUT bits read back 0
    applyStimulus(BASE + 32'h14, 1, 4'hF, 32'hFFFF_FFFF, rd);
    applyStimulus(BASE + 32'h14, 0, 4'hF, 32'h0, rd);
    checkOutput("out_hi_mask", rd, 32'h0000_003F);

    // Edge capture and interrupt on pad 33
    applyStimulus(BASE + 32'h2C, 1, 4'hF, 32'h2, rd);
    io_in[33] = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    checkOutput("irq_before", irq, 1'b0);
    @(posedge wb_clk_i); #1;
    checkOutput("irq_rise", irq, 1'b1);
    applyStimulus(BASE + 32'h24, 0, 4'hF, 32'h0, rd);
    checkOutput("edge_hi_set", rd, 32'h2);
    applyStimulus(BASE + 32'h1C, 0, 4'hF, 32'h0, rd);
    checkOutput("in_hi", rd, 32'h2);
    applyStimulus(BASE + 32'h24, 1, 4'hF, 32'h2, rd);
    checkOutput("irq_cleared", irq, 1'b0);
    applyStimulus(BASE + 32'h24, 0, 4'hF, 32'h0, rd);
    checkOutput("edge_hi_clr", rd, 32'h0);

    // Set and clear in the same cycle: set wins
    io_in[33] = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    io_in[33] = 1'b1;
    @(posedge wb_clk_i); #1;
    applyStimulus(BASE + 32'h24, 1, 4'hF, 32'h2, rd);
    applyStimulus(BASE + 32'h24, 0, 4'hF, 32'h0, rd);
    checkOutput("edge_set_wins", rd, 32'h2);
    // W1C without lane 0 enabled leaves the bit alone
    applyStimulus(BASE + 32'h24, 1, 4'b1110, 32'h2, rd);
    applyStimulus(BASE + 32'h24, 0, 4'hF, 32'h0, rd);
    checkOutput("edge_sel_w1c", rd, 32'h2);
    applyStimulus(BASE + 32'h24, 1, 4'hF, 32'hFFFF_FFFF, rd);

    // Held stb acks every other cycle
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h10;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    checkOutput("held_stb_acks", acks, 2);
    @(posedge wb_clk_i); #1;

    // Outside the window: never acked
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE + 32'h40;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
      checkOutput("oow_dat", wbs_dat_o, 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    checkOutput("oow_acks", acks, 0);

    // Unmapped offset: acked, reads 0, ignores writes
    applyStimulus(BASE + 32'h34, 1, 4'hF, 32'hDEAD_BEEF, rd);
    applyStimulus(BASE + 32'h34, 0, 4'hF, 32'h0, rd);
    checkOutput("unmapped_rd", rd, 32'h0);

    // Reset during a write strobe
    io_in = '0;
    core_out = 16'hA5A5; core_oeb = 16'h0000;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h1234_5678;
    wb_rst_i  = 1'b1;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wb_rst_i  = 1'b0;
    checkOutput("rst_mid_ack", wbs_ack_o, 1'b0);
    checkOutput("rst_mid_oeb", io_oeb, {11'h7FF, 16'h0000, 11'h7FF});
    checkOutput("rst_mid_out", io_out, {11'h7FF, 16'hA5A5, 11'h7FF});
    checkOutput("rst_mid_irq", irq, 1'b0);
    applyStimulus(BASE + 32'h10, 0, 4'hF, 32'h0, rd);
    checkOutput("rst_mid_outlo", rd, 32'h0);

    repeat (2) @(posedge wb_clk_i);
    #1;
    cmpOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
